// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: FIFO-buffered command front end that drives the 4-bit ALU, waits SETTLE cycles and returns the sampled result.
// Define ALU_ISSUER_ZFLAG_EN to add the rsp_zero output.
module alu_cmd_issuer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [1:0] cmd_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_y,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_y,
  output logic       rsp_cout,
  output logic [1:0] rsp_op,
`ifdef ALU_ISSUER_ZFLAG_EN
  output logic       rsp_zero,
`endif
  output logic       busy
);

  localparam int          AW         = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [AW:0] EMPTY_CNT  = {(AW+1){1'b0}};
  localparam logic [3:0]  SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [9:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [3:0]    cnt_r;
  logic [1:0]    op_q_r;
  logic [9:0]    head_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          capture_s;
  logic          hshake_s;

  assign empty_s   = (count_r == EMPTY_CNT);
  assign cmd_ready = (count_r != FULL_CNT);
  assign push_s    = cmd_valid & cmd_ready;
  assign head_s    = mem_r[rd_ptr_r];
  assign busy      = (state_r != IDLE) | ~empty_s;

  // FIFO storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 10'd0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= EMPTY_CNT;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {cmd_a, cmd_b, cmd_op};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) state_nxt_s = DRIVE;
        else          state_nxt_s = IDLE;
      end
      DRIVE: begin
        if (cnt_r == 4'd1) state_nxt_s = RESP;
        else               state_nxt_s = DRIVE;
      end
      RESP: begin
        if (rsp_ready) begin
          if (!empty_s) state_nxt_s = DRIVE;
          else          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM strobes: a pop happens from IDLE or on the response handshake, never while driving
  always_comb begin
    pop_s     = 1'b0;
    capture_s = 1'b0;
    hshake_s  = 1'b0;
    case (state_r)
      IDLE: begin
        pop_s = ~empty_s;
      end
      DRIVE: begin
        capture_s = (cnt_r == 4'd1);
      end
      RESP: begin
        hshake_s = rsp_valid & rsp_ready;
        pop_s    = rsp_valid & rsp_ready & ~empty_s;
      end
      default: begin
        pop_s     = 1'b0;
        capture_s = 1'b0;
        hshake_s  = 1'b0;
      end
    endcase
  end

  // ALU drive and settle counter; the drive only changes on a pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= 4'd0;
      alu_b   <= 4'd0;
      alu_sel <= 2'd0;
      op_q_r  <= 2'd0;
      cnt_r   <= 4'd0;
    end else if (pop_s) begin
      alu_a   <= head_s[9:6];
      alu_b   <= head_s[5:2];
      alu_sel <= head_s[1:0];
      op_q_r  <= head_s[1:0];
      cnt_r   <= SETTLE_CNT;
    end else if (state_r == DRIVE) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Response capture; carry is undefined for logic ops so it is cleared for them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_y     <= 4'd0;
      rsp_cout  <= 1'b0;
      rsp_op    <= 2'd0;
`ifdef ALU_ISSUER_ZFLAG_EN
      rsp_zero  <= 1'b0;
`endif
    end else if (capture_s) begin
      rsp_valid <= 1'b1;
      rsp_y     <= alu_y;
      rsp_cout  <= (op_q_r[1] == 1'b0) ? alu_cout : 1'b0;
      rsp_op    <= op_q_r;
`ifdef ALU_ISSUER_ZFLAG_EN
      rsp_zero  <= (alu_y == 4'd0);
`endif
    end else if (hshake_s) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed steps plus random traffic scored against an in-order reference model.
// A second instance with SETTLE=3 covers settle-time sampling and asynchronous reset mid-operation.
module tb_alu_cmd_issuer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance 0: SETTLE=1
  logic       cmd_valid, cmd_ready, alu_cout, rsp_valid, rsp_ready, rsp_cout, busy;
  logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, rsp_y;
  logic [1:0] cmd_op, alu_sel, rsp_op;
  // instance 1: SETTLE=3
  logic       cmd_valid1, cmd_ready1, alu_cout1, rsp_valid1, rsp_ready1, rsp_cout1, busy1;
  logic [3:0] cmd_a1, cmd_b1, alu_a1, alu_b1, alu_y1, rsp_y1;
  logic [1:0] cmd_op1, alu_sel1, rsp_op1;
  logic       ovr1;
  logic [3:0] ovr_y1;
  logic [4:0] m0, m1;
`ifdef ALU_ISSUER_ZFLAG_EN
  logic       rsp_zero, rsp_zero1;
`endif

  // Behavioural 4-bit ALU: {cout, y}; cout deliberately 1 for logic ops
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    logic [4:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {(a < b), 4'(a - b)};
      2'b10:   r = {1'b1, a & b};
      default: r = {1'b1, a | b};
    endcase
    return r;
  endfunction

  // Expected response {y, cout, op}
  function automatic logic [6:0] expect_rsp(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    logic [4:0] r;
    r = alu_model(a, b, op);
    return {r[3:0], (op[1] ? 1'b0 : r[4]), op};
  endfunction

  assign m0 = alu_model(alu_a, alu_b, alu_sel);
  assign alu_y = m0[3:0];
  assign alu_cout = m0[4];
  assign m1 = alu_model(alu_a1, alu_b1, alu_sel1);
  assign alu_y1 = ovr1 ? ovr_y1 : m1[3:0];
  assign alu_cout1 = m1[4];

  alu_cmd_issuer #(.DEPTH(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_cout(rsp_cout), .rsp_op(rsp_op),
`ifdef ALU_ISSUER_ZFLAG_EN
    .rsp_zero(rsp_zero),
`endif
    .busy(busy)
  );

  alu_cmd_issuer #(.DEPTH(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_op(cmd_op1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_y(alu_y1), .alu_cout(alu_cout1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_y(rsp_y1), .rsp_cout(rsp_cout1), .rsp_op(rsp_op1),
`ifdef ALU_ISSUER_ZFLAG_EN
    .rsp_zero(rsp_zero1),
`endif
    .busy(busy1)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         n_acc = 0;
  logic [9:0] exp_q[$];
  logic [6:0] rsp_log[$];
  int         rsp_cyc[$];
  logic       hold_pending = 1'b0;
  logic [6:0] held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on instance 0: drive at the falling edge, score responses, record accepted commands
  task automatic cycle(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input logic rr);
    logic [9:0] e;
    @(negedge clk);
    cyc++;
    cmd_valid = v; cmd_a = a; cmd_b = b; cmd_op = op; rsp_ready = rr;
    if (hold_pending) check("rsp_hold", {rsp_valid, rsp_y, rsp_cout, rsp_op}, {1'b1, held});
    hold_pending = 1'b0;
    if (rsp_valid) begin
      if (rr) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", {rsp_y, rsp_cout, rsp_op}, expect_rsp(e[9:6], e[5:2], e[1:0]));
`ifdef ALU_ISSUER_ZFLAG_EN
          check("rsp_zero", rsp_zero, (expect_rsp(e[9:6], e[5:2], e[1:0]) >> 3) == 7'd0);
`endif
        end
        rsp_log.push_back({rsp_y, rsp_cout, rsp_op});
        rsp_cyc.push_back(cyc);
      end else begin
        hold_pending = 1'b1;
        held = {rsp_y, rsp_cout, rsp_op};
      end
    end
    if (v && cmd_ready) begin
      exp_q.push_back({a, b, op});
      n_acc++;
    end
  endtask

  task automatic drain(input int target, input int budget);
    int i = 0;
    while (rsp_log.size() < target && i < budget) begin
      cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
      i++;
    end
    check("drain_count", rsp_log.size(), target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, acc0, t_acc, seen;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_a = 4'h0; cmd_b = 4'h0; cmd_op = 2'b00; rsp_ready = 1'b0;
    cmd_valid1 = 1'b0; cmd_a1 = 4'h0; cmd_b1 = 4'h0; cmd_op1 = 2'b00; rsp_ready1 = 1'b0;
    ovr1 = 1'b0; ovr_y1 = 4'h0;
    #12;
    check("reset_outs", {cmd_ready, rsp_valid, rsp_y, rsp_cout, rsp_op, alu_a, alu_b, alu_sel, busy},
          {1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // add 9+8, latency and drive
    cycle(1'b1, 4'h9, 4'h8, 2'b00, 1'b1);
    t_acc = cyc;
    cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
    check("add_lat0", {rsp_valid, busy}, {1'b0, 1'b1});
    cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
    check("add_drive", {alu_a, alu_b, alu_sel, rsp_valid}, {4'h9, 4'h8, 2'b00, 1'b0});
    cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
    check("add_count", rsp_log.size(), 1);
    if (rsp_log.size() == 1) begin
      check("add_rsp", rsp_log[0], {4'h1, 1'b1, 2'b00});
      check("add_latency", rsp_cyc[0] - t_acc, 3);
    end
    cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
    check("add_idle", {rsp_valid, busy}, {1'b0, 1'b0});

    // sub and logic back-to-back
    base = rsp_log.size();
    cycle(1'b1, 4'h3, 4'h5, 2'b01, 1'b1);
    cycle(1'b1, 4'hC, 4'hA, 2'b10, 1'b1);
    cycle(1'b1, 4'hC, 4'h3, 2'b11, 1'b1);
    drain(base + 3, 40);
    if (rsp_log.size() >= base + 3) begin
      check("sub_rsp", rsp_log[base], {4'hE, 1'b1, 2'b01});
      check("and_rsp", rsp_log[base+1], {4'h8, 1'b0, 2'b10});
      check("or_rsp", rsp_log[base+2], {4'hF, 1'b0, 2'b11});
      check("spacing1", rsp_cyc[base+1] - rsp_cyc[base], 2);
      check("spacing2", rsp_cyc[base+2] - rsp_cyc[base+1], 2);
    end

    // backpressure: DEPTH queued plus one in flight
    cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    base = rsp_log.size();
    acc0 = n_acc;
    for (int i = 0; i < 7; i++) cycle(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0);
    check("bp_accepted", n_acc - acc0, 5);
    check("bp_ready_low", cmd_ready, 1'b0);
    cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
    @(posedge clk); #1;
    check("bp_ready_back", cmd_ready, 1'b1);
    drain(base + 5, 60);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
    drain(n_acc, 300);
    cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
    check("rand_empty", {exp_q.size() == 0, busy}, {1'b1, 1'b0});

`ifdef ALU_ISSUER_ZFLAG_EN
    base = rsp_log.size();
    cycle(1'b1, 4'h5, 4'h5, 2'b01, 1'b1);
    drain(base + 1, 20);
    if (rsp_log.size() >= base + 1) check("zero_rsp", rsp_log[base], {4'h0, 1'b0, 2'b01});
`endif

    // settle sampling on SETTLE=3 instance
    @(negedge clk);
    cmd_valid1 = 1'b1; cmd_a1 = 4'h9; cmd_b1 = 4'h9; cmd_op1 = 2'b00; rsp_ready1 = 1'b1;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    @(negedge clk);
    ovr1 = 1'b1; ovr_y1 = 4'h0;
    check("settle_drv0", {alu_a1, alu_b1, alu_sel1, rsp_valid1}, {4'h9, 4'h9, 2'b00, 1'b0});
    @(negedge clk);
    ovr_y1 = 4'h5;
    check("settle_drv1", {alu_a1, alu_b1, alu_sel1, rsp_valid1}, {4'h9, 4'h9, 2'b00, 1'b0});
    @(negedge clk);
    ovr_y1 = 4'hA;
    check("settle_drv2", {alu_a1, alu_b1, alu_sel1, rsp_valid1}, {4'h9, 4'h9, 2'b00, 1'b0});
    @(negedge clk);
    check("settle_rsp", {rsp_valid1, rsp_y1, rsp_cout1, rsp_op1}, {1'b1, 4'hA, 1'b1, 2'b00});
    ovr1 = 1'b0;
    @(negedge clk);
    check("settle_done", {rsp_valid1, busy1}, {1'b0, 1'b0});

    // asynchronous reset while driving with two commands queued
    rsp_ready1 = 1'b0;
    cmd_valid1 = 1'b1; cmd_a1 = 4'h3; cmd_b1 = 4'h4; cmd_op1 = 2'b11;
    @(negedge clk);
    cmd_a1 = 4'h5; cmd_b1 = 4'h6; cmd_op1 = 2'b00;
    @(negedge clk);
    cmd_a1 = 4'h7; cmd_b1 = 4'h1; cmd_op1 = 2'b01;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    check("rst_pre", {alu_a1, alu_b1, alu_sel1, busy1, rsp_valid1}, {4'h3, 4'h4, 2'b11, 1'b1, 1'b0});
    #2 rst_n = 1'b0;
    #1;
    check("rst_now", {rsp_valid1, busy1, alu_a1, alu_b1, alu_sel1, cmd_ready1}, {1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready1 = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid1) seen++;
    end
    check("rst_no_rsp", seen, 0);
    check("rst_idle", busy1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side front end for the 4-bit ALU. It accepts operation commands over a valid/ready interface and buffers them in a small FIFO. Each command drives the ALU operand/select inputs and holds them for a programmable settle time, then samples the ALU result and returns it over a second valid/ready interface. It sits between the control/test logic and the ALU datapath and is the only block that drives the ALU inputs.

## Interface
- DEPTH, 4, command FIFO entries; power of two, 2..16
- SETTLE, 1, cycles ALU inputs are held before the result is sampled; 1..15
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; equals !full (registered count)
- cmd_a, cmd_b  in  4  operands
- cmd_op  in  2  00 add, 01 sub, 10 and, 11 or
- alu_a, alu_b  out  4  registered ALU operand drive
- alu_sel  out  2  registered ALU select drive
- alu_y  in  4  ALU result
- alu_cout  in  1  ALU carry/borrow
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_y  out  4  captured result
- rsp_cout  out  1  captured carry; forced 0 for op 10/11
- rsp_op  out  2  op of the response
- busy  out  1  high when state != IDLE or FIFO non-empty

## Operation
- Push: cmd_valid & cmd_ready at a rising edge writes {a,b,op} to the FIFO.
- cmd_ready depends only on the registered count; a push into a full FIFO is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop on a non-full FIFO: count unchanged; pointers wrap modulo DEPTH.
- FSM states: IDLE, DRIVE, RESP.
- IDLE: if FIFO is non-empty, pop and load alu_a/alu_b/alu_sel plus op_q, load cnt=SETTLE, then go to DRIVE. Otherwise stay.
- DRIVE: decrement cnt each cycle. On the edge where cnt==1:
  - load rsp_y=alu_y;
  - load rsp_cout = alu_cout for op 00/01, 0 otherwise (the ALU does not define Cout for logic ops);
  - load rsp_op=op_q;
  - set rsp_valid=1 and go to RESP.
- RESP: hold all rsp_* stable while rsp_valid & !rsp_ready. On the handshake edge:
  - if the FIFO is non-empty, pop the next command, load the ALU drive and cnt, and go to DRIVE (rsp_valid=0);
  - otherwise go to IDLE.
- alu_* hold their last value in IDLE and RESP; they change only on a pop.
- Arithmetic is performed by the ALU. This block treats alu_y/alu_cout as opaque, with no width extension.
- Capacity: DEPTH queued plus 1 in flight. With rsp_ready=0, DEPTH+1 commands are accepted before cmd_ready drops.

## Timing
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_y=0, rsp_cout=0, rsp_op=0;
  - alu_a=alu_b=0, alu_sel=0, busy=0;
  - FIFO empty, state IDLE.
- Latency: command accepted at edge N into an empty, idle block → popped at N+1 → rsp_valid high after edge N+1+SETTLE.
- Throughput: with rsp_ready held high and the FIFO non-empty, one response per SETTLE+1 cycles.
- Reset mid-operation: all state clears immediately and asynchronously, queued and in-flight commands are discarded, and rsp_valid drops without a handshake.
- All outputs are registered except cmd_ready (from registered count) and busy (from registered state and count).

## Configuration
- ALU_ISSUER_ZFLAG_EN defined: adds output rsp_zero (1 bit), loaded with (alu_y==0) at capture, reset 0, held with the other rsp_* signals.
- ALU_ISSUER_ZFLAG_EN undefined: the port and its register are absent; all other behaviour is identical.

## Test plan
- Add with SETTLE=1: A=9, B=8, op 00, rsp_ready=1 → rsp_y=1, rsp_cout=1, rsp_op=00; rsp_valid rises 2 edges after acceptance.
- Sub and logic back-to-back:
  - A=3, B=5, op 01 → Y=E, Cout=1;
  - A=C, B=A, op 10 → Y=8, Cout=0;
  - A=C, B=3, op 11 → Y=F, Cout=0;
  - responses arrive in order, spaced SETTLE+1 cycles.
- Backpressure with DEPTH=4, rsp_ready=0: push 7 commands → exactly 5 accepted, cmd_ready=0 afterwards; release rsp_ready → 5 responses in order, and cmd_ready returns after the first pop.
- Settle: SETTLE=3, alu_y stimulus changes during the first 2 DRIVE cycles → the captured value equals alu_y in the final DRIVE cycle; alu_a/b/sel are stable for all 3 cycles.
- Reset in DRIVE with 2 commands queued → rsp_valid=0, busy=0, alu_*=0 immediately; no response is produced after release.
- With ALU_ISSUER_ZFLAG_EN: A=5, B=5, op 01 → rsp_y=0, rsp_zero=1, rsp_cout=0.
